// File: rtl/seq_mult_sa.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_sa
// Description : Sequential shift-add multiplier, unsigned or two's-complement
//               signed, with early termination once the remaining multiplier
//               bits are zero. Operands A and B arrive on consecutive cycles
//               over a shared bus; the exact 2*WIDTH-bit product is flagged by
//               a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_sa #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [WIDTH-1:0] C_ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    C_ONE_P = {{(PW-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,   state_d;
  logic             mode_q,    mode_d;
  logic             neg_q,     neg_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic [PW-1:0]    product_q, product_d;

  logic             w_din_signed;
  logic             w_din_neg;
  logic [WIDTH-1:0] w_din_mag;
  logic [PW-1:0]    w_acc_neg;

  // Magnitude of the operand currently on the bus; mode comes from sgn in the
  // A cycle and from the latched mode in the B cycle. -2^(W-1) maps to
  // 2^(W-1), which is still representable as an unsigned W-bit value.
  always_comb begin
    w_din_signed = (state_q == S_IDLE) ? sgn : mode_q;
    w_din_neg    = w_din_signed & data_in[WIDTH-1];
    w_din_mag    = w_din_neg ? ((~data_in) + C_ONE_W) : data_in;
    w_acc_neg    = (~acc_q) + C_ONE_P;
  end

  // Next-state and datapath update for the shift-add sequence.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = sgn;
          neg_d   = w_din_neg;
          mcand_d = {{WIDTH{1'b0}}, w_din_mag};
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        mplier_d = w_din_mag;
        neg_d    = neg_q ^ w_din_neg;
        acc_d    = '0;
        state_d  = S_CALC;
      end
      S_CALC: begin
        if (mplier_q == '0) begin
          // Negating a zero accumulator yields zero, so no -0 pattern arises.
          product_d = neg_q ? w_acc_neg : acc_q;
          state_d   = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_sa.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_sa
// Description : Scoreboard bench for seq_mult_sa at WIDTH=16 and WIDTH=8.
//               Stimulus pushes expected product and completion cycle; per-DUT
//               monitors pop and compare on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_sa;

  typedef struct {
    logic [31:0] prod;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        st16, sg16;
  logic [15:0] din16;
  logic        busy16, done16;
  logic [31:0] prod16;

  logic        st8, sg8;
  logic [7:0]  din8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  exp_t        q16[$];
  exp_t        q8[$];

  seq_mult_sa #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (st16),
    .sgn     (sg16),
    .data_in (din16),
    .busy    (busy16),
    .done    (done16),
    .product (prod16)
  );

  seq_mult_sa #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (st8),
    .sgn     (sg8),
    .data_in (din8),
    .busy    (busy8),
    .done    (done8),
    .product (prod8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare product, completion cycle and busy on each done pulse.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        check("unexpected_done16", 64'd1, 64'd0);
      end else begin
        e = q16.pop_front();
        check("product16", {32'h0, prod16}, {32'h0, e.prod});
        check("latency16", 64'(cyc), 64'(e.cyc));
        check("busy_at_done16", {63'h0, busy16}, 64'd1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("product8", {48'h0, prod8}, {32'h0, e.prod});
        check("latency8", 64'(cyc), 64'(e.cyc));
        check("busy_at_done8", {63'h0, busy8}, 64'd1);
      end
    end
  end

  // Drive A with start, then B, then garbage; expected done appears k+2 edges
  // after the B edge, i.e. at counter value (now + 3 + k) on the negedge.
  task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] p, input int k);
    exp_t e;
    @(negedge clk);
    e.prod = p;
    e.cyc  = cyc + 3 + k;
    if (w8) begin
      st8 = 1'b1; din8 = a[7:0]; sg8 = s; q8.push_back(e);
    end else begin
      st16 = 1'b1; din16 = a; sg16 = s; q16.push_back(e);
    end
    @(negedge clk);
    if (w8) begin
      st8 = 1'b0; din8 = b[7:0]; sg8 = ~s;
    end else begin
      st16 = 1'b0; din16 = b; sg16 = ~s;
    end
    @(negedge clk);
    if (w8) din8 = 8'($urandom);
    else    din16 = 16'($urandom);
  endtask

  // Wait (bounded) for done; optionally require the old product to hold.
  task automatic wait_done(input bit w8, input bit hold_en, input logic [31:0] hold);
    bit          seen;
    logic        dn;
    logic [31:0] pr;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      dn = w8 ? done8 : done16;
      pr = w8 ? {16'h0, prod8} : prod16;
      if (dn) seen = 1'b1;
      else if (hold_en) check("product_hold", {32'h0, pr}, {32'h0, hold});
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    st16 = 1'b0; sg16 = 1'b0; din16 = '0;
    st8  = 1'b0; sg8  = 1'b0; din8  = '0;
    #13;
    check("reset_busy16", {63'h0, busy16}, 64'd0);
    check("reset_done16", {63'h0, done16}, 64'd0);
    check("reset_prod16", {32'h0, prod16}, 64'd0);
    check("reset_busy8",  {63'h0, busy8},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=16 directed vectors
    issue(0, 16'd3, 16'd5, 1'b0, 32'h0000000F, 3);
    check("busy_in_calc16", {63'h0, busy16}, 64'd1);
    wait_done(0, 1'b0, '0);
    issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16);
    wait_done(0, 1'b0, '0);
    @(negedge clk);
    check("busy_after_done16", {63'h0, busy16}, 64'd0);
    check("done_after_done16", {63'h0, done16}, 64'd0);
    issue(0, 16'hFFFD, 16'd7, 1'b1, 32'hFFFFFFEB, 3);
    wait_done(0, 1'b0, '0);
    issue(0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16);
    wait_done(0, 1'b0, '0);
    issue(0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1);
    wait_done(0, 1'b0, '0);
    issue(0, 16'h8000, 16'hFFFF, 1'b1, 32'h00008000, 1);
    wait_done(0, 1'b0, '0);
    issue(0, 16'hFFFF, 16'h0000, 1'b1, 32'h00000000, 0);
    wait_done(0, 1'b0, '0);
    issue(0, 16'h1234, 16'h0000, 1'b0, 32'h00000000, 0);
    wait_done(0, 1'b0, '0);
    issue(0, 16'h0000, 16'h0100, 1'b0, 32'h00000000, 9);
    wait_done(0, 1'b0, '0);

    // start pulse during CALC must be ignored
    issue(0, 16'd6, 16'd4, 1'b0, 32'd24, 3);
    st16 = 1'b1; din16 = 16'd9; sg16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    wait_done(0, 1'b0, '0);

    // back-to-back start in the first IDLE cycle; 24 must hold meanwhile
    issue(0, 16'd7, 16'd9, 1'b0, 32'd63, 4);
    wait_done(0, 1'b1, 32'd24);

    // asynchronous reset mid-CALC, then a fresh operation
    issue(0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 8);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy16", {63'h0, busy16}, 64'd0);
    check("midreset_done16", {63'h0, done16}, 64'd0);
    check("midreset_prod16", {32'h0, prod16}, 64'd0);
    void'(q16.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 16'd2, 16'd3, 1'b0, 32'd6, 2);
    wait_done(0, 1'b0, '0);

    // WIDTH=8 directed vectors
    issue(1, 16'h03, 16'h05, 1'b0, 32'h000F, 3);
    wait_done(1, 1'b0, '0);
    issue(1, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 8);
    wait_done(1, 1'b0, '0);
    @(negedge clk);
    check("busy_after_done8", {63'h0, busy8}, 64'd0);
    issue(1, 16'hFD, 16'h07, 1'b1, 32'hFFEB, 3);
    wait_done(1, 1'b0, '0);
    issue(1, 16'h80, 16'h80, 1'b1, 32'h4000, 8);
    wait_done(1, 1'b0, '0);
    issue(1, 16'h80, 16'h01, 1'b1, 32'hFF80, 1);
    wait_done(1, 1'b0, '0);

    repeat (3) @(negedge clk);
    check("q16_drained", 64'(q16.size()), 64'd0);
    check("q8_drained",  64'(q8.size()),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
